// File: rtl/cov_pkg.sv
// Shared coverage types and helpers used by the accumulator and the stagnation monitor.
package cov_pkg;

  localparam int unsigned COV_SUM_W     = 30;
  localparam int unsigned COV_POP_CHUNK = 32;
  localparam int unsigned COV_POP_CNT_W = $clog2(COV_POP_CHUNK) + 1;

  typedef logic [COV_SUM_W-1:0] cov_sum_t;

  // Number of set bits in one popcount slice.
  function automatic logic [COV_POP_CNT_W-1:0] popcount_chunk(input logic [COV_POP_CHUNK-1:0] v);
    logic [COV_POP_CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < COV_POP_CHUNK; i++) begin
      n = n + COV_POP_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cov_popcount_tree.sv
// Combinational reduction of the per-slice partial popcounts into one delta.
module cov_popcount_tree #(
  parameter int unsigned N_CHUNKS = 8,
  parameter int unsigned PART_W   = 6,
  parameter int unsigned DELTA_W  = 9
) (
  input  logic [N_CHUNKS-1:0][PART_W-1:0] parts,
  output logic [DELTA_W-1:0]              delta_c
);

  always_comb begin
    delta_c = '0;
    for (int unsigned k = 0; k < N_CHUNKS; k++) begin
      delta_c = delta_c + DELTA_W'(parts[k]);
    end
  end

endmodule

// File: rtl/cov_accumulator.sv
// Sticky coverage bitmap with a 3-stage pipeline counting newly covered points into cov_sum.
module cov_accumulator
  import cov_pkg::*;
#(
  parameter int unsigned N_POINTS  = 256,
  parameter int unsigned SUM_W     = COV_SUM_W,
  parameter int unsigned POP_CHUNK = COV_POP_CHUNK
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                hit_valid,
  input  logic [N_POINTS-1:0] hit,
  output logic [SUM_W-1:0]    cov_sum,
  output logic                new_cov,
  output logic                map_full
);

  localparam int unsigned N_CHUNKS = N_POINTS / POP_CHUNK;
  localparam int unsigned PART_W   = COV_POP_CNT_W;
  localparam int unsigned DELTA_W  = $clog2(N_POINTS) + 1;

  logic [N_POINTS-1:0]              seen;
  logic [N_POINTS-1:0]              fresh_q;
  logic [N_POINTS-1:0]              hit_gated_c;
  logic [N_CHUNKS-1:0][PART_W-1:0]  part_q;
  logic [DELTA_W-1:0]               delta_c;
  logic [SUM_W:0]                   sum_wide_c;
  logic [SUM_W-1:0]                 sum_next_c;

  // Qualify hits so an undriven hit bus cannot reach the bitmap.
  assign hit_gated_c = hit & {N_POINTS{hit_valid}};

  // Stage 1: isolate first-time hits and update the sticky bitmap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seen    <= '0;
      fresh_q <= '0;
    end else if (clear) begin
      seen    <= '0;
      fresh_q <= '0;
    end else begin
      fresh_q <= hit_gated_c & ~seen;
      seen    <= seen | hit_gated_c;
    end
  end

  // Stage 2: per-slice partial popcounts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      part_q <= '0;
    end else if (clear) begin
      part_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CHUNKS; k++) begin
        part_q[k] <= popcount_chunk(fresh_q[k*POP_CHUNK +: POP_CHUNK]);
      end
    end
  end

  cov_popcount_tree #(
    .N_CHUNKS (N_CHUNKS),
    .PART_W   (PART_W),
    .DELTA_W  (DELTA_W)
  ) u_tree (
    .parts   (part_q),
    .delta_c (delta_c)
  );

  // Saturate at N_POINTS; reaching the clamp indicates a bitmap bug upstream.
  always_comb begin
    sum_wide_c = {1'b0, cov_sum} + (SUM_W+1)'(delta_c);
    sum_next_c = sum_wide_c[SUM_W-1:0];
    if (sum_wide_c > (SUM_W+1)'(N_POINTS)) begin
      sum_next_c = SUM_W'(N_POINTS);
    end
  end

  // Stage 3: running total and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cov_sum  <= '0;
      new_cov  <= 1'b0;
      map_full <= 1'b0;
    end else if (clear) begin
      cov_sum  <= '0;
      new_cov  <= 1'b0;
      map_full <= 1'b0;
    end else begin
      cov_sum  <= sum_next_c;
      new_cov  <= (delta_c != '0);
      map_full <= (sum_next_c == SUM_W'(N_POINTS));
    end
  end

  overflow_clamp_a: assert property (
    @(posedge clock) disable iff (!reset_n)
    clear || (sum_wide_c <= (SUM_W+1)'(N_POINTS))
  );

endmodule

// File: tb/tb_cov_accumulator.sv
// Directed bench for cov_accumulator with a set-based coverage model checked every cycle.
module tb_cov_accumulator;

  localparam int N = 256;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          hit_valid;
  logic [N-1:0]  hit;
  logic [29:0]   cov_sum;
  logic          new_cov;
  logic          map_full;

  int errors = 0;
  int checks = 0;

  // Model: set of points seen this round, pending new-point counts, committed total.
  bit [N-1:0] m_seen;
  int         m_sum;
  bit         m_new;
  int         m_pipe [2];

  always #5 clock = ~clock;

  cov_accumulator dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .hit_valid (hit_valid),
    .hit       (hit),
    .cov_sum   (cov_sum),
    .new_cov   (new_cov),
    .map_full  (map_full)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seen    = '0;
    m_sum     = 0;
    m_new     = 1'b0;
    m_pipe[0] = 0;
    m_pipe[1] = 0;
  endtask

  // Newly seen points become visible three edges after the cycle they arrive.
  task automatic model_edge(input bit clr, input bit v, input bit [N-1:0] h);
    if (!reset_n || clr) begin
      model_reset();
    end else begin
      int d = m_pipe[0];
      m_sum     = (m_sum + d > N) ? N : m_sum + d;
      m_new     = (d != 0);
      m_pipe[0] = m_pipe[1];
      m_pipe[1] = v ? $countones(h & ~m_seen) : 0;
      if (v) m_seen |= h;
    end
  endtask

  task automatic compare();
    check("cov_sum", cov_sum, m_sum);
    check("new_cov", new_cov, m_new);
    check("map_full", map_full, m_sum == N);
  endtask

  task automatic cycle(input bit clr, input bit v, input logic [N-1:0] h);
    clear     = clr;
    hit_valid = v;
    hit       = h;
    @(posedge clock);
    model_edge(clr, v, h);
    @(negedge clock);
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0);
  endtask

  function automatic logic [N-1:0] hbit(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  logic [N-1:0] ones;
  logic [N-1:0] v6;
  logic [N-1:0] v7;

  initial begin
    ones      = '1;
    v6        = N'(64'h0000_00F0_0000_0003);
    v7        = N'(64'h0000_0000_0000_0007);
    clear     = 1'b0;
    hit_valid = 1'b0;
    hit       = '0;
    reset_n   = 1'b0;
    model_reset();
    @(negedge clock);

    // Reset held with all hits valid: nothing may accumulate.
    repeat (3) begin
      cycle(1'b0, 1'b1, ones);
      check("reset_sum", cov_sum, 0);
      check("reset_full", map_full, 0);
    end
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, ones);
    idle(1);
    check("rel_sum_early", cov_sum, 0);
    idle(1);
    check("rel_sum", cov_sum, 256);
    check("rel_full", map_full, 1);
    check("rel_new", new_cov, 1);

    // Single point with repeats.
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, hbit(7));
    cycle(1'b0, 1'b1, hbit(7));
    check("sp_lat1", cov_sum, 0);
    idle(1);
    check("sp_lat2", cov_sum, 1);
    check("sp_new", new_cov, 1);
    idle(1);
    check("sp_new_drop", new_cov, 0);
    idle(6);
    cycle(1'b0, 1'b1, hbit(7));
    idle(4);
    check("sp_repeat", cov_sum, 1);

    // Asynchronous reset drops state without a clock edge.
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", cov_sum, 0);
    @(negedge clock);
    cycle(1'b0, 1'b0, '0);
    reset_n = 1'b1;

    // Multi-point first hits add in one step.
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, v6);
    idle(2);
    check("multi6", cov_sum, 6);
    check("multi6_new", new_cov, 1);
    idle(1);
    check("multi6_one_pulse", new_cov, 0);
    cycle(1'b0, 1'b1, v7);
    idle(2);
    check("multi7", cov_sum, 7);

    // Clear race drops in-flight work.
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, hbit(3));
    cycle(1'b1, 1'b1, hbit(4));
    check("race_t1", cov_sum, 0);
    cycle(1'b0, 1'b1, hbit(4));
    idle(1);
    check("race_t3", cov_sum, 0);
    idle(1);
    check("race_t5", cov_sum, 1);
    cycle(1'b0, 1'b1, hbit(3));
    idle(2);
    check("race_rehit3", cov_sum, 2);

    // Gating by hit_valid.
    cycle(1'b1, 1'b0, '0);
    repeat (50) cycle(1'b0, 1'b0, ones);
    check("gate_sum", cov_sum, 0);
    cycle(1'b0, 1'b1, hbit(0));
    idle(2);
    check("gate_bit0", cov_sum, 1);

    // Full sweep, one new point per cycle.
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, hbit(i));
    check("sweep_mid", cov_sum, 254);
    idle(2);
    check("sweep_sum", cov_sum, 256);
    check("sweep_full", map_full, 1);
    cycle(1'b0, 1'b1, ones);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("sweep_nopulse", new_cov, 0);
    end
    check("sweep_hold", cov_sum, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
